aes_key_expand: RTL and testbench

//   AES-128 key schedule stage, upstream of the aes core. Expands the 128-bit

---
 rtl/aes_key_expand.sv | 144 ++++++++++++++
 tb/tb_aes_key_expand.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands a cipher key into 11 round keys, one per clock,
// and serves any stored round key through a registered read port.

module aes_key_expand_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // FIPS-197 forward S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bitpos;

  assign bitpos = 11'd2047 - {a, 3'b000};
  assign y      = SBOX[bitpos -: 8];

endmodule

module aes_key_expand #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic         start,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         ready,
  output logic         done
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] keys [0:NUM_ROUNDS];

  logic [3:0]   prev_idx;
  logic [127:0] prev;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic [127:0] next_key;

  assign prev_idx = cnt - 4'd1;
  assign prev     = (prev_idx <= LAST) ? keys[prev_idx] : '0;
  assign {w0, w1, w2, w3} = prev;
  assign rot = {w3[23:0], w3[31:24]};

  aes_key_expand_sbox u_sbox0 (.a(rot[31:24]), .y(sub[31:24]));
  aes_key_expand_sbox u_sbox1 (.a(rot[23:16]), .y(sub[23:16]));
  aes_key_expand_sbox u_sbox2 (.a(rot[15:8]),  .y(sub[15:8]));
  aes_key_expand_sbox u_sbox3 (.a(rot[7:0]),   .y(sub[7:0]));

  always_comb begin
    rcon = 8'h00;
    case (cnt)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t        = sub ^ {rcon, 24'h000000};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      round_key <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      done      <= 1'b0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
        keys[i] <= '0;
      end
    end else begin
      done      <= 1'b0;
      round_key <= (round_sel <= LAST) ? keys[round_sel] : '0;
      case (state)
        IDLE, READY: begin
          // A start from READY restarts exactly like one from IDLE
          if (start) begin
            keys[0] <= key;
            cnt     <= 4'd1;
            state   <= EXPAND;
            busy    <= 1'b1;
            ready   <= 1'b0;
          end
        end
        EXPAND: begin
          keys[cnt] <= next_key;
          cnt       <= cnt + 4'd1;
          if (cnt == LAST) begin
            state <= READY;
            busy  <= 1'b0;
            ready <= 1'b1;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed-vector bench for aes_key_expand using FIPS-197 key schedule vectors.

module tb_aes_key_expand;

  logic         clk;
  logic         reset;
  logic [127:0] key;
  logic         start;
  logic [3:0]   round_sel;
  logic [127:0] round_key;
  logic         busy;
  logic         ready;
  logic         done;

  int vectors;
  int miscompares;

  localparam logic [127:0] K1_0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1_1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K1_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K2_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_key_expand #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .start     (start),
    .round_sel (round_sel),
    .round_key (round_key),
    .busy      (busy),
    .ready     (ready),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, then count further edges until ready (bounded)
  task automatic expand(input logic [127:0] k, output int n);
    key   = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic read_key(input logic [3:0] sel, input string tag, input logic [127:0] exp);
    round_sel = sel;
    @(posedge clk); #1;
    check(tag, round_key, exp);
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    key         = '0;
    start       = 1'b0;
    round_sel   = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {127'b0, busy}, 128'd0);
    check("rst_ready", {127'b0, ready}, 128'd0);
    check("rst_done", {127'b0, done}, 128'd0);
    check("rst_round_key", round_key, '0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Vector 1
    key   = K1_0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("v1_busy_after_start", {127'b0, busy}, 128'd1);
    check("v1_ready_after_start", {127'b0, ready}, 128'd0);
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("v1_latency", 128'(n), 128'd10);
    check("v1_done_pulse", {127'b0, done}, 128'd1);
    check("v1_busy_clear", {127'b0, busy}, 128'd0);
    @(posedge clk); #1;
    check("v1_done_one_cycle", {127'b0, done}, 128'd0);
    check("v1_ready_held", {127'b0, ready}, 128'd1);
    read_key(4'd0, "v1_k0", K1_0);
    read_key(4'd1, "v1_k1", K1_1);
    read_key(4'd10, "v1_k10", K1_10);

    // Restart from READY with vector 2: ready drops on the start edge
    key   = K2_0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("v2_ready_drops", {127'b0, ready}, 128'd0);
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("v2_latency", 128'(n), 128'd10);
    read_key(4'd0, "v2_k0", K2_0);
    read_key(4'd1, "v2_k1", K2_1);
    read_key(4'd10, "v2_k10", K2_10);

    // start re-pulsed mid-EXPAND with another key is ignored
    key   = K1_0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!ready && n < 20) begin
      if (n == 4) begin
        key   = 128'hffeeddccbbaa99887766554433221100;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("v3_latency", 128'(n), 128'd10);
    read_key(4'd0, "v3_k0", K1_0);
    read_key(4'd1, "v3_k1", K1_1);
    read_key(4'd10, "v3_k10", K1_10);

    // Read port: out-of-range indices and one-cycle latency
    for (int s = 11; s < 16; s++) begin
      read_key(4'(s), "sel_out_of_range", '0);
    end
    read_key(4'd1, "sel_1", K1_1);
    round_sel = 4'd10;
    #2;
    check("sel_latency_hold", round_key, K1_1);
    @(posedge clk); #1;
    check("sel_latency_update", round_key, K1_10);

    // Async reset between edges, mid-EXPAND
    round_sel = 4'd1;
    key   = K2_0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("mid_busy_before_rst", {127'b0, busy}, 128'd1);
    reset = 1'b0;
    #1;
    check("arst_busy", {127'b0, busy}, 128'd0);
    check("arst_ready", {127'b0, ready}, 128'd0);
    check("arst_done", {127'b0, done}, 128'd0);
    check("arst_round_key", round_key, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_ready", {127'b0, ready}, 128'd0);
    check("post_rst_busy", {127'b0, busy}, 128'd0);
    read_key(4'd0, "post_rst_k0", '0);

    // Fresh expansion after reset still works
    expand(K2_0, n);
    check("v4_latency", 128'(n), 128'd10);
    read_key(4'd10, "v4_k10", K2_10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
